// File: rtl/pia_kbd_feeder_pkg.sv
// Shared types and constants for the PIA keyboard feeder: FSM states,
// ASCII case-folding constants and the byte conversion applied on push.
package pia_kbd_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT_ACK
    } state_t;

    localparam logic [7:0] ASCII_LOWER_A     = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;
    localparam logic [7:0] PA_IDLE_VALUE     = 8'hFF;

    function automatic logic [7:0] kbd_convert(
        input logic [7:0] data,
        input logic       upcase,
        input logic       force_b7
    );
        logic [7:0] result;
        result = data;
        if (upcase && (data >= ASCII_LOWER_A) && (data <= ASCII_LOWER_Z)) begin
            result = data - ASCII_CASE_OFFSET;
        end
        if (force_b7) begin
            result[7] = 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pia_kbd_feeder_fifo.sv
// Small circular byte FIFO with wrapping pointers; the head entry is readable
// combinationally so a pop and the load of the head happen on the same edge.
module kbd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [7:0]               i_push_data,
    input  logic                     i_pop,
    output logic [7:0]               o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage is not reset; flushing is done by clearing pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pia_kbd_feeder.sv
// Feeds buffered ASCII bytes to MC6820 port A: present on PAI, strobe CA1,
// then hold the byte until the CPU reads peripheral register A.
module pia_kbd_feeder
    import pia_kbd_feeder_pkg::*;
#(
    parameter int          DEPTH             = 4,
    parameter int          SETUP_CYCLES      = 1,
    parameter int          STROBE_CYCLES     = 2,
    parameter logic [15:0] ACK_TIMEOUT       = 16'd0,
    parameter bit          STROBE_ACTIVE_LOW = 1'b1,
    parameter bit          UPCASE            = 1'b1,
    parameter bit          FORCE_B7          = 1'b1
) (
    input  logic                   i_enable,
    input  logic                   i_reset,
    input  logic [7:0]             i_kb_data,
    input  logic                   i_kb_valid,
    output logic                   o_kb_ready,
    input  logic                   i_pa_read,
    output logic [7:0]             o_pa_out,
    output logic                   o_ca1_out,
    output logic [$clog2(DEPTH):0] o_fifo_count,
    output logic                   o_busy
);
    localparam logic        CA1_IDLE    = STROBE_ACTIVE_LOW;
    localparam logic        CA1_ACTIVE  = ~STROBE_ACTIVE_LOW;
    localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] ACK_LAST    = ACK_TIMEOUT - 16'd1;

    generate
        if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $fatal(1, "pia_kbd_feeder: DEPTH must be a power of two in 2..16");
        end
        if ((SETUP_CYCLES < 1) || (SETUP_CYCLES > 15)) begin : g_bad_setup
            $fatal(1, "pia_kbd_feeder: SETUP_CYCLES must be in 1..15");
        end
        if ((STROBE_CYCLES < 1) || (STROBE_CYCLES > 15)) begin : g_bad_strobe
            $fatal(1, "pia_kbd_feeder: STROBE_CYCLES must be in 1..15");
        end
    endgenerate

    state_t      r_state, w_state_next;
    logic [15:0] r_timer, w_timer_next;
    logic        r_ack_pending, w_ack_pending_next;
    logic [7:0]  r_pa_out, w_pa_out_next;
    logic        r_ca1, w_ca1_next;
    logic        w_pop;
    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_head;
    logic [7:0]  w_push_data;
    logic [15:0] w_timer_inc;

    assign o_kb_ready  = ~w_full;
    assign w_push      = i_kb_valid & ~w_full;
    assign w_push_data = kbd_convert(i_kb_data, UPCASE, FORCE_B7);
    assign w_timer_inc = (r_timer == 16'hFFFF) ? r_timer : r_timer + 16'd1;

    kbd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk       (i_enable),
        .i_rst       (i_reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (o_fifo_count)
    );

    always_comb begin
        w_state_next       = r_state;
        w_timer_next       = r_timer;
        w_ack_pending_next = r_ack_pending;
        w_pa_out_next      = r_pa_out;
        w_pop              = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop              = 1'b1;
                    w_pa_out_next      = w_head;
                    w_ack_pending_next = 1'b0;
                    w_timer_next       = '0;
                    w_state_next       = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (i_pa_read) w_ack_pending_next = 1'b1;
                if (r_timer >= SETUP_LAST) begin
                    w_timer_next = '0;
                    w_state_next = ST_STROBE;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            ST_STROBE: begin
                if (i_pa_read) w_ack_pending_next = 1'b1;
                if (r_timer >= STROBE_LAST) begin
                    w_timer_next = '0;
                    w_state_next = ST_WAIT_ACK;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            ST_WAIT_ACK: begin
                // An ack on the same edge as the timeout takes priority.
                if (i_pa_read || r_ack_pending) begin
                    w_state_next = ST_IDLE;
                end else if ((ACK_TIMEOUT != 16'd0) && (r_timer >= ACK_LAST)) begin
                    w_timer_next = '0;
                    w_state_next = ST_SETUP;
                end else begin
                    w_timer_next = w_timer_inc;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        w_ca1_next = (w_state_next == ST_STROBE) ? CA1_ACTIVE : CA1_IDLE;
    end

    always_ff @(posedge i_enable or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_ack_pending <= 1'b0;
            r_pa_out      <= PA_IDLE_VALUE;
            r_ca1         <= CA1_IDLE;
        end else begin
            r_state       <= w_state_next;
            r_timer       <= w_timer_next;
            r_ack_pending <= w_ack_pending_next;
            r_pa_out      <= w_pa_out_next;
            r_ca1         <= w_ca1_next;
        end
    end

    assign o_pa_out  = r_pa_out;
    assign o_ca1_out = r_ca1;
    assign o_busy    = (r_state != ST_IDLE);

endmodule
